// File: rtl/mmap_arbiter.sv
// mmap_arbiter: round-robin sharing of the user_app memory-map port
// between two request/ack requesters, with tagged fixed-latency read return.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_wr_en/addr/data per-port write requests (port p in slice p)
//   req_rd_en/addr      per-port read requests
//   req_ack             per-port grant, combinational, one-hot or zero
//   req_rd_data/valid   per-port read return, registered 1-cycle pulse
//   mmap_wr_*/mmap_rd_* registered single-cycle downstream strobes
//   mmap_rd_data        downstream read data, RD_LATENCY after mmap_rd_en
module mmap_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_wr_en,
    input  logic [2*ADDR_WIDTH-1:0] req_wr_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wr_data,
    input  logic [1:0]              req_rd_en,
    input  logic [2*ADDR_WIDTH-1:0] req_rd_addr,
    output logic [1:0]              req_ack,
    output logic [2*DATA_WIDTH-1:0] req_rd_data,
    output logic [1:0]              req_rd_valid,
    output logic                    mmap_wr_en,
    output logic [ADDR_WIDTH-1:0]   mmap_wr_addr,
    output logic [DATA_WIDTH-1:0]   mmap_wr_data,
    output logic                    mmap_rd_en,
    output logic [ADDR_WIDTH-1:0]   mmap_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mmap_rd_data
);

    logic [1:0]            req_any;
    logic                  last_grant;
    logic                  gnt_vld;
    logic                  gnt_port;
    logic                  gnt_wr;
    logic                  gnt_rd;
    logic [ADDR_WIDTH-1:0] sel_wr_addr;
    logic [DATA_WIDTH-1:0] sel_wr_data;
    logic [ADDR_WIDTH-1:0] sel_rd_addr;
    logic                  rd_port;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_port;

    assign req_any = req_wr_en | req_rd_en;

    // Requests seen while rst is high are ignored entirely.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        if (!rst && req_any != 2'b00) begin
            gnt_vld = 1'b1;
            if (req_any == 2'b11)
                gnt_port = ~last_grant;
            else
                gnt_port = req_any[1];
        end
    end

    always_comb begin
        req_ack = 2'b00;
        if (gnt_vld)
            req_ack[gnt_port] = 1'b1;
    end

    // A port holding both write and read gets its write serviced first.
    assign gnt_wr = gnt_vld & req_wr_en[gnt_port];
    assign gnt_rd = gnt_vld & ~req_wr_en[gnt_port];

    assign sel_wr_addr = gnt_port ? req_wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_wr_addr[ADDR_WIDTH-1:0];
    assign sel_wr_data = gnt_port ? req_wr_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_wr_data[DATA_WIDTH-1:0];
    assign sel_rd_addr = gnt_port ? req_rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_rd_addr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            mmap_wr_en   <= 1'b0;
            mmap_wr_addr <= '0;
            mmap_wr_data <= '0;
            mmap_rd_en   <= 1'b0;
            mmap_rd_addr <= '0;
            rd_port      <= 1'b0;
        end else begin
            mmap_wr_en <= gnt_wr;
            mmap_rd_en <= gnt_rd;
            if (gnt_vld)
                last_grant <= gnt_port;
            if (gnt_wr) begin
                mmap_wr_addr <= sel_wr_addr;
                mmap_wr_data <= sel_wr_data;
            end
            if (gnt_rd) begin
                mmap_rd_addr <= sel_rd_addr;
                rd_port      <= gnt_port;
            end
        end
    end

    // Tag pipeline: the issuing port rides alongside the read so it
    // emerges in the same cycle user_app presents the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld      <= '0;
            tag_port     <= '0;
            req_rd_valid <= 2'b00;
            req_rd_data  <= '0;
        end else begin
            tag_vld[0]  <= mmap_rd_en;
            tag_port[0] <= rd_port;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
            req_rd_valid <= 2'b00;
            if (tag_vld[RD_LATENCY-1]) begin
                req_rd_valid[tag_port[RD_LATENCY-1]] <= 1'b1;
                if (tag_port[RD_LATENCY-1])
                    req_rd_data[2*DATA_WIDTH-1:DATA_WIDTH] <= mmap_rd_data;
                else
                    req_rd_data[DATA_WIDTH-1:0] <= mmap_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mmap_arbiter.sv
// tb_mmap_arbiter: random request/ack traffic on two arbiter instances
// (read latency 1 and 4) compared cycle by cycle with a transaction model.
module tb_mmap_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_en = 2'b00;
    logic [1:0]  rd_en = 2'b00;
    logic [63:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [63:0] rd_addr = '0;

    logic [1:0]  ack [2];
    logic [63:0] rdat [2];
    logic [1:0]  rval [2];
    logic        mwe [2];
    logic        mre [2];
    logic [31:0] mwa [2];
    logic [31:0] mwd [2];
    logic [31:0] mra [2];
    logic [31:0] mrd [2];

    mmap_arbiter #(.RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_wr_en(wr_en), .req_wr_addr(wr_addr), .req_wr_data(wr_data),
        .req_rd_en(rd_en), .req_rd_addr(rd_addr),
        .req_ack(ack[0]), .req_rd_data(rdat[0]), .req_rd_valid(rval[0]),
        .mmap_wr_en(mwe[0]), .mmap_wr_addr(mwa[0]), .mmap_wr_data(mwd[0]),
        .mmap_rd_en(mre[0]), .mmap_rd_addr(mra[0]), .mmap_rd_data(mrd[0])
    );

    mmap_arbiter #(.RD_LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst),
        .req_wr_en(wr_en), .req_wr_addr(wr_addr), .req_wr_data(wr_data),
        .req_rd_en(rd_en), .req_rd_addr(rd_addr),
        .req_ack(ack[1]), .req_rd_data(rdat[1]), .req_rd_valid(rval[1]),
        .mmap_wr_en(mwe[1]), .mmap_wr_addr(mwa[1]), .mmap_wr_data(mwd[1]),
        .mmap_rd_en(mre[1]), .mmap_rd_addr(mra[1]), .mmap_rd_data(mrd[1])
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Reference model state: memory contents as seen in issue order,
    // per-cycle expected downstream/return events in a small ring.
    logic [31:0] mm [16];
    logic [31:0] env [2][16];
    logic [31:0] env_rd [2][16];
    bit          ev_we [16];
    bit          ev_re [16];
    logic [31:0] ev_wa [16];
    logic [31:0] ev_wd [16];
    logic [31:0] ev_ra [16];
    bit          ev_rv [2][16];
    bit          ev_rp [2][16];
    logic [31:0] ev_rd [2][16];
    logic [31:0] h_wa, h_wd, h_ra;
    logic [31:0] h_rd [2][2];
    bit          last_g;

    bit          pw [2];
    bit          pr [2];
    logic [31:0] qa_w [2];
    logic [31:0] qd_w [2];
    logic [31:0] qa_r [2];
    logic [1:0]  prev_ack;

    initial begin
        int s, n, m, kind;
        bit g;
        logic [1:0] reqv, e_ack;
        logic [1:0] e_rv [2];
        logic [31:0] tmp, a, b;
        logic e_we, e_re;

        for (int i = 0; i < 16; i++) begin
            mm[i] = $urandom;
            ev_we[i] = 0;
            ev_re[i] = 0;
            for (int k = 0; k < 2; k++) begin
                env[k][i] = mm[i];
                env_rd[k][i] = $urandom;
                ev_rv[k][i] = 0;
            end
        end
        h_wa = '0; h_wd = '0; h_ra = '0;
        for (int k = 0; k < 2; k++) begin
            h_rd[k][0] = '0;
            h_rd[k][1] = '0;
            mrd[k] = '0;
        end
        last_g = 1'b1;
        prev_ack = 2'b00;
        for (int p = 0; p < 2; p++) begin
            pw[p] = 0; pr[p] = 0;
            qa_w[p] = '0; qd_w[p] = '0; qa_r[p] = '0;
        end

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            s = c % 16;

            e_we = ev_we[s];
            e_re = ev_re[s];
            if (e_we) begin
                h_wa = ev_wa[s];
                h_wd = ev_wd[s];
            end
            if (e_re)
                h_ra = ev_ra[s];
            ev_we[s] = 0;
            ev_re[s] = 0;
            for (int k = 0; k < 2; k++) begin
                e_rv[k] = 2'b00;
                if (ev_rv[k][s]) begin
                    e_rv[k][ev_rp[k][s]] = 1'b1;
                    h_rd[k][ev_rp[k][s]] = ev_rd[k][s];
                    ev_rv[k][s] = 0;
                end
                check($sformatf("L%0d wr_en", lat(k)), 64'(mwe[k]), 64'(e_we));
                check($sformatf("L%0d wr_addr", lat(k)), 64'(mwa[k]), 64'(h_wa));
                check($sformatf("L%0d wr_data", lat(k)), 64'(mwd[k]), 64'(h_wd));
                check($sformatf("L%0d rd_en", lat(k)), 64'(mre[k]), 64'(e_re));
                check($sformatf("L%0d rd_addr", lat(k)), 64'(mra[k]), 64'(h_ra));
                check($sformatf("L%0d rd_valid", lat(k)), 64'(rval[k]), 64'(e_rv[k]));
                check($sformatf("L%0d rd_data", lat(k)), rdat[k],
                      {h_rd[k][1], h_rd[k][0]});
            end

            // user_app register file driven by each instance's strobes
            for (int k = 0; k < 2; k++) begin
                if (mwe[k] === 1'b1)
                    env[k][mwa[k][5:2]] = mwd[k];
                if (mre[k] === 1'b1)
                    env_rd[k][(c + lat(k)) % 16] = env[k][mra[k][5:2]];
                mrd[k] = env_rd[k][s];
                env_rd[k][s] = $urandom;
            end

            // requesters: hold until acked, then drop or change
            for (int p = 0; p < 2; p++) begin
                if (prev_ack[p]) begin
                    if (pw[p]) pw[p] = 0;
                    else pr[p] = 0;
                end
                if (!pw[p] && !pr[p] && $urandom_range(0, 3) != 0) begin
                    kind = $urandom_range(0, 2);
                    tmp = $urandom;
                    a = {tmp[31:6], 4'($urandom_range(0, 15)), 2'b00};
                    tmp = $urandom;
                    b = {tmp[31:6], 4'($urandom_range(0, 15)), 2'b00};
                    pw[p] = (kind != 1);
                    pr[p] = (kind != 0);
                    qa_w[p] = a;
                    qd_w[p] = $urandom;
                    qa_r[p] = (kind == 2) ? a : b;
                end
                wr_en[p] = pw[p];
                rd_en[p] = pr[p];
                wr_addr[p*32 +: 32] = qa_w[p];
                wr_data[p*32 +: 32] = qd_w[p];
                rd_addr[p*32 +: 32] = qa_r[p];
            end
            rst = (c < 3) || (c == 600) || (c == 1300);
            #1;

            e_ack = 2'b00;
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    ev_we[i] = 0;
                    ev_re[i] = 0;
                    ev_rv[0][i] = 0;
                    ev_rv[1][i] = 0;
                end
                h_wa = '0; h_wd = '0; h_ra = '0;
                for (int k = 0; k < 2; k++) begin
                    h_rd[k][0] = '0;
                    h_rd[k][1] = '0;
                end
                last_g = 1'b1;
            end else begin
                reqv = {pw[1] | pr[1], pw[0] | pr[0]};
                if (reqv != 2'b00) begin
                    g = (reqv == 2'b11) ? !last_g : reqv[1];
                    last_g = g;
                    e_ack[g] = 1'b1;
                    n = (c + 1) % 16;
                    if (pw[g]) begin
                        ev_we[n] = 1;
                        ev_wa[n] = qa_w[g];
                        ev_wd[n] = qd_w[g];
                        mm[qa_w[g][5:2]] = qd_w[g];
                    end else begin
                        ev_re[n] = 1;
                        ev_ra[n] = qa_r[g];
                        for (int k = 0; k < 2; k++) begin
                            m = (c + lat(k) + 2) % 16;
                            ev_rv[k][m] = 1;
                            ev_rp[k][m] = g;
                            ev_rd[k][m] = mm[qa_r[g][5:2]];
                        end
                    end
                end
            end
            for (int k = 0; k < 2; k++)
                check($sformatf("L%0d ack", lat(k)), 64'(ack[k]), 64'(e_ack));
            prev_ack = e_ack;
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
